// File: rtl/truth_table_checker.sv
// rtl/truth_table_checker.sv - sequential truth-table response checker for 3-input boolean blocks
//
// Consumes handshaked (x, y, z, s) samples and compares each s against EXPECT[{x,y,z}].
// Tracks which of the 8 input rows have been seen and counts accepted and mismatching samples.
// Flags done/pass once every row is covered.
//
// Optional macro: FIRST_FAIL_CAPTURE_EN
//   When defined, the row of the first mismatch since start is captured on fail_row/fail_valid.
//   When undefined, fail_row and fail_valid are tied to 0.
//
// Ports:
//   clk          in   clock, rising edge
//   rst          in   asynchronous active-high reset
//   start        in   one-cycle pulse: clear results and enter RUN
//   in_valid     in   sample present on x, y, z, s
//   in_ready     out  checker accepts a sample this cycle (state == RUN)
//   x, y, z      in   DUT inputs of the sample
//   s            in   DUT output of the sample
//   covered      out  bit i set once row i = {x,y,z} has been accepted
//   err_count    out  mismatching samples, saturating
//   sample_count out  accepted samples, saturating at 255
//   busy         out  state == RUN
//   done         out  state == DONE
//   pass         out  done with no mismatches
//   fail_row     out  row of first mismatch
//   fail_valid   out  fail_row holds a capture

module truth_table_checker #(
    parameter logic [7:0] EXPECT = 8'h2A,
    parameter int         ERRW   = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            x,
    input  logic            y,
    input  logic            z,
    input  logic            s,
    output logic [7:0]      covered,
    output logic [ERRW-1:0] err_count,
    output logic [7:0]      sample_count,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [2:0]      fail_row,
    output logic            fail_valid
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      covered_q, covered_d;
    logic [ERRW-1:0] err_q, err_d;
    logic [7:0]      cnt_q, cnt_d;

    logic [2:0]      idx;
    logic [7:0]      covered_next;
    logic            accept;
    logic            mismatch;

    assign idx          = {x, y, z};
    assign covered_next = covered_q | (8'd1 << idx);
    assign accept       = in_valid && (state_q == ST_RUN);
    assign mismatch     = (s != EXPECT[idx]);

    // start has priority over a sample presented in the same cycle.
    logic take;
    assign take = accept && !start;

    always_comb begin
        state_d   = state_q;
        covered_d = covered_q;
        err_d     = err_q;
        cnt_d     = cnt_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    covered_d = 8'h00;
                    err_d     = '0;
                    cnt_d     = 8'h00;
                end
            end
            ST_RUN: begin
                if (start) begin
                    covered_d = 8'h00;
                    err_d     = '0;
                    cnt_d     = 8'h00;
                end else if (take) begin
                    covered_d = covered_next;
                    if (cnt_q != 8'hFF) begin
                        cnt_d = cnt_q + 8'd1;
                    end
                    if (mismatch && (err_q != {ERRW{1'b1}})) begin
                        err_d = err_q + ERRW'(1);
                    end
                    if (covered_next == 8'hFF) begin
                        state_d = ST_DONE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            covered_q <= 8'h00;
            err_q     <= '0;
            cnt_q     <= 8'h00;
        end else begin
            state_q   <= state_d;
            covered_q <= covered_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
        end
    end

`ifdef FIRST_FAIL_CAPTURE_EN
    logic [2:0] fail_row_q, fail_row_d;
    logic       fail_valid_q, fail_valid_d;

    always_comb begin
        fail_row_d   = fail_row_q;
        fail_valid_d = fail_valid_q;
        if (start) begin
            fail_row_d   = 3'd0;
            fail_valid_d = 1'b0;
        end else if (take && mismatch && !fail_valid_q) begin
            fail_row_d   = idx;
            fail_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_row_q   <= 3'd0;
            fail_valid_q <= 1'b0;
        end else begin
            fail_row_q   <= fail_row_d;
            fail_valid_q <= fail_valid_d;
        end
    end

    assign fail_row   = fail_row_q;
    assign fail_valid = fail_valid_q;
`else
    assign fail_row   = 3'd0;
    assign fail_valid = 1'b0;
`endif

    assign in_ready     = (state_q == ST_RUN);
    assign busy         = (state_q == ST_RUN);
    assign done         = (state_q == ST_DONE);
    assign pass         = (state_q == ST_DONE) && (err_q == '0);
    assign covered      = covered_q;
    assign err_count    = err_q;
    assign sample_count = cnt_q;

endmodule
